mem_arbiter_responder: RTL and testbench

Memory-side responder for the dual-core MIPS system. Two cores (each with its own cache) issue read/write requests on `r_enN`/`w_enN`; this block arbitrates between them, sequences a single-port synchronous main memory, returns read data, stalls the requester until completion, and broadcasts a write-invalidate to the other core's cache. It sits between both `mips_multi` instances and `memoria_principal`.

---
 rtl/mem_arbiter_responder_if.sv | 59 +++++
 rtl/mem_arbiter_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_responder_if
//  Description : Bus bundle between two core-side caches, the memory
//                responder and the single-port main memory.
//  Revision    : 1.0
// ============================================================================
interface mem_arbiter_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    // Core 1
    logic              r_en1;
    logic              w_en1;
    logic [ADDR_W-1:0] address1;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] rdata1;
    logic              done1;
    logic              stall1;
    // Core 2
    logic              r_en2;
    logic              w_en2;
    logic [ADDR_W-1:0] address2;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] rdata2;
    logic              done2;
    logic              stall2;
    // Cache invalidate broadcast
    logic              inv1;
    logic              inv2;
    logic [ADDR_W-1:0] inv_addr;
    // Main memory
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output r_en1, w_en1, address1, data1,
        output r_en2, w_en2, address2, data2,
        output mem_q,
        input  rdata1, done1, stall1,
        input  rdata2, done2, stall2,
        input  inv1, inv2, inv_addr,
        input  mem_addr, mem_data, mem_rden, mem_wren
    );

    modport slave (
        input  r_en1, w_en1, address1, data1,
        input  r_en2, w_en2, address2, data2,
        input  mem_q,
        output rdata1, done1, stall1,
        output rdata2, done2, stall2,
        output inv1, inv2, inv_addr,
        output mem_addr, mem_data, mem_rden, mem_wren
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_responder
//  Description : Round-robin arbiter and sequencer for a single-port
//                synchronous memory shared by two cores, with write-invalidate.
//  Revision    : 1.0
// ============================================================================
module mem_arbiter_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_arbiter_responder_if.slave bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCESS   = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;
    localparam logic [2:0] c_LAT_LAST = 3'(MEM_LAT - 1);

    logic [1:0]        r_state,    w_state_nxt;
    logic              r_gnt2,     w_gnt2_nxt;
    logic              r_last2,    w_last2_nxt;
    logic              r_is_wr,    w_is_wr_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic [DATA_W-1:0] r_mem_data, w_mem_data_nxt;
    logic [2:0]        r_cnt,      w_cnt_nxt;
    logic              r_rden,     w_rden_nxt;
    logic              r_wren,     w_wren_nxt;
    logic              r_done1,    w_done1_nxt;
    logic              r_done2,    w_done2_nxt;
    logic              r_inv1,     w_inv1_nxt;
    logic              r_inv2,     w_inv2_nxt;
    logic [ADDR_W-1:0] r_inv_addr, w_inv_addr_nxt;
    logic [DATA_W-1:0] r_rdata1,   w_rdata1_nxt;
    logic [DATA_W-1:0] r_rdata2,   w_rdata2_nxt;

    logic              w_pend1;
    logic              w_pend2;
    logic              w_pick2;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_pend1    = bus.r_en1 | bus.w_en1;
    assign w_pend2    = bus.r_en2 | bus.w_en2;
    // r_last2 set means core 2 was served last, so core 1 wins a tie
    assign w_pick2    = w_pend2 & (~w_pend1 | ~r_last2);
    assign w_sel_wr   = w_pick2 ? bus.w_en2    : bus.w_en1;
    assign w_sel_addr = w_pick2 ? bus.address2 : bus.address1;
    assign w_sel_data = w_pick2 ? bus.data2    : bus.data1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_gnt2     <= 1'b0;
            r_last2    <= 1'b1;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_mem_data <= '0;
            r_cnt      <= '0;
            r_rden     <= 1'b0;
            r_wren     <= 1'b0;
            r_done1    <= 1'b0;
            r_done2    <= 1'b0;
            r_inv1     <= 1'b0;
            r_inv2     <= 1'b0;
            r_inv_addr <= '0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt2     <= w_gnt2_nxt;
            r_last2    <= w_last2_nxt;
            r_is_wr    <= w_is_wr_nxt;
            r_addr     <= w_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rden     <= w_rden_nxt;
            r_wren     <= w_wren_nxt;
            r_done1    <= w_done1_nxt;
            r_done2    <= w_done2_nxt;
            r_inv1     <= w_inv1_nxt;
            r_inv2     <= w_inv2_nxt;
            r_inv_addr <= w_inv_addr_nxt;
            r_rdata1   <= w_rdata1_nxt;
            r_rdata2   <= w_rdata2_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt2_nxt     = r_gnt2;
        w_last2_nxt    = r_last2;
        w_is_wr_nxt    = r_is_wr;
        w_addr_nxt     = r_addr;
        w_mem_data_nxt = r_mem_data;
        w_cnt_nxt      = r_cnt;
        w_inv_addr_nxt = r_inv_addr;
        w_rdata1_nxt   = r_rdata1;
        w_rdata2_nxt   = r_rdata2;
        w_rden_nxt     = 1'b0;
        w_wren_nxt     = 1'b0;
        w_done1_nxt    = 1'b0;
        w_done2_nxt    = 1'b0;
        w_inv1_nxt     = 1'b0;
        w_inv2_nxt     = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (w_pend1 | w_pend2) begin
                    w_gnt2_nxt  = w_pick2;
                    w_last2_nxt = w_pick2;
                    w_is_wr_nxt = w_sel_wr;
                    w_addr_nxt  = w_sel_addr;
                    // Enables are registered here so they are high exactly during ACCESS
                    if (w_sel_wr) begin
                        w_wren_nxt     = 1'b1;
                        w_mem_data_nxt = w_sel_data;
                    end else begin
                        w_rden_nxt     = 1'b1;
                    end
                    w_state_nxt = c_ACCESS;
                end
            end

            c_ACCESS: begin
                w_cnt_nxt = '0;
                if (r_is_wr) begin
                    w_done1_nxt    = ~r_gnt2;
                    w_done2_nxt    = r_gnt2;
                    w_inv1_nxt     = r_gnt2;
                    w_inv2_nxt     = ~r_gnt2;
                    w_inv_addr_nxt = r_addr;
                    w_state_nxt    = c_DONE;
                end else begin
                    w_state_nxt    = c_WAIT;
                end
            end

            c_WAIT: begin
                if (r_cnt == c_LAT_LAST) begin
                    if (r_gnt2) begin
                        w_rdata2_nxt = bus.mem_q;
                    end else begin
                        w_rdata1_nxt = bus.mem_q;
                    end
                    w_done1_nxt = ~r_gnt2;
                    w_done2_nxt = r_gnt2;
                    w_state_nxt = c_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + 3'd1;
                end
            end

            c_DONE: begin
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign bus.stall1   = w_pend1 & ~r_done1;
    assign bus.stall2   = w_pend2 & ~r_done2;
    assign bus.done1    = r_done1;
    assign bus.done2    = r_done2;
    assign bus.rdata1   = r_rdata1;
    assign bus.rdata2   = r_rdata2;
    assign bus.inv1     = r_inv1;
    assign bus.inv2     = r_inv2;
    assign bus.inv_addr = r_inv_addr;
    assign bus.mem_addr = r_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.mem_rden = r_rden;
    assign bus.mem_wren = r_wren;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_responder
//  Description : Scoreboard bench for mem_arbiter_responder with a behavioural
//                memory at latency 1 and a second instance at latency 4.
//  Revision    : 1.0
// ============================================================================
module tb_mem_arbiter_responder;

    localparam int c_AW = 12;
    localparam int c_DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    mem_arbiter_responder_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus  ();
    mem_arbiter_responder_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus4 ();

    mem_arbiter_responder #(.ADDR_W(c_AW), .DATA_W(c_DW), .MEM_LAT(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter_responder #(.ADDR_W(c_AW), .DATA_W(c_DW), .MEM_LAT(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    // Behavioural single-port memory shared by both instances
    logic [c_DW-1:0] mem [0:(1<<c_AW)-1];
    logic [c_DW-1:0] pipe4 [0:3];
    logic            pl_we   = 1'b0;
    logic [c_AW-1:0] pl_addr = '0;
    logic [c_DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_data;
        else if (pl_we)   mem[pl_addr]      <= pl_data;
        bus.mem_q <= bus.mem_rden  ? mem[bus.mem_addr]  : 32'hBAD0_BAD0;
        pipe4[0]  <= bus4.mem_rden ? mem[bus4.mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign bus4.mem_q = pipe4[3];

    typedef struct packed {
        logic            core2;
        logic            wr;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(posedge clk); #2;
        pl_we   = 1'b0;
    endtask

    task automatic drive(input bit c2, input bit rd, input bit wr,
                         input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        if (c2) begin
            bus.r_en2 = rd; bus.w_en2 = wr; bus.address2 = a; bus.data2 = d;
        end else begin
            bus.r_en1 = rd; bus.w_en1 = wr; bus.address1 = a; bus.data1 = d;
        end
    endtask

    task automatic push_exp(input bit c2, input bit wr, input logic [c_AW-1:0] a,
                            input logic [c_DW-1:0] d);
        exp_t e;
        e.core2 = c2;
        e.wr    = wr;
        e.addr  = a;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Pops the expected transaction whenever a done pulse appears
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("stall1", 32'(bus.stall1), 32'((bus.r_en1 | bus.w_en1) & ~bus.done1));
                chk("stall2", 32'(bus.stall2), 32'((bus.r_en2 | bus.w_en2) & ~bus.done2));
                if (bus.done1 | bus.done2) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'({bus.done2, bus.done1}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_core", 32'({bus.done2, bus.done1}),
                            e.core2 ? 32'd2 : 32'd1);
                        if (!e.wr)
                            chk("rdata", e.core2 ? bus.rdata2 : bus.rdata1, e.data);
                        chk("inv_pair", 32'({bus.inv2, bus.inv1}),
                            !e.wr ? 32'd0 : (e.core2 ? 32'd1 : 32'd2));
                        if (e.wr)
                            chk("inv_addr", 32'(bus.inv_addr), 32'(e.addr));
                    end
                end else begin
                    chk("inv_quiet", 32'({bus.inv2, bus.inv1}), 32'd0);
                end
            end
        end
    endtask

    // One complete transaction on the latency-1 instance; called at posedge+2
    task automatic txn(input bit c2, input bit rd, input bit wr,
                       input logic [c_AW-1:0] a, input logic [c_DW-1:0] d,
                       input logic [c_DW-1:0] exp_rd, input int exp_cyc);
        int cyc    = 0;
        int en_cnt = 0;
        push_exp(c2, wr, a, exp_rd);
        drive(c2, rd, wr, a, d);
        do begin
            @(negedge clk);
            cyc++;
            if (bus.mem_rden | bus.mem_wren) begin
                en_cnt++;
                chk("en_kind", 32'({bus.mem_wren, bus.mem_rden}), wr ? 32'd2 : 32'd1);
                chk("mem_addr", 32'(bus.mem_addr), 32'(a));
                if (wr) chk("mem_data", bus.mem_data, d);
            end
        end while (!(c2 ? bus.done2 : bus.done1) && cyc < 40);
        chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("en_cycles", 32'(en_cnt), 32'd1);
        @(posedge clk); #2;
        drive(c2, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        int cyc;
        int cnt;
        rst  = 1'b0;
        rst4 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        bus4.r_en1 = 1'b0; bus4.w_en1 = 1'b0; bus4.address1 = '0; bus4.data1 = '0;
        bus4.r_en2 = 1'b0; bus4.w_en2 = 1'b0; bus4.address2 = '0; bus4.data2 = '0;

        // A request held during reset must show up as a stall only
        bus.r_en1 = 1'b1;
        bus.address1 = 12'h123;
        preload(12'h123, 32'hDEAD_BEEF);
        preload(12'h010, 32'h1010_0101);
        preload(12'h020, 32'h2020_0202);
        preload(12'h321, 32'hCAFE_F00D);
        preload(12'h322, 32'h1234_5678);
        @(negedge clk);
        chk("rst_stall1",   32'(bus.stall1),   32'd1);
        chk("rst_stall2",   32'(bus.stall2),   32'd0);
        chk("rst_done",     32'({bus.done2, bus.done1}), 32'd0);
        chk("rst_inv",      32'({bus.inv2, bus.inv1}),   32'd0);
        chk("rst_inv_addr", 32'(bus.inv_addr), 32'd0);
        chk("rst_rdata1",   bus.rdata1,        32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_data", bus.mem_data,      32'd0);
        chk("rst_mem_en",   32'({bus.mem_wren, bus.mem_rden}), 32'd0);
        bus.r_en1 = 1'b0;
        @(posedge clk); #2;
        rst  = 1'b1;
        rst4 = 1'b1;
        fork
            monitor();
        join_none
        @(posedge clk); #2;

        // Simultaneous reads held for four grants: order 1,2,1,2
        drive(1'b0, 1'b1, 1'b0, 12'h010, '0);
        drive(1'b1, 1'b1, 1'b0, 12'h020, '0);
        for (int k = 0; k < 4; k++)
            push_exp(k % 2 == 1, 1'b0, (k % 2 == 1) ? 12'h020 : 12'h010,
                     (k % 2 == 1) ? 32'h2020_0202 : 32'h1010_0101);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!(bus.done1 | bus.done2) && cyc < 40);
            chk("pair_latency", 32'(cyc), 32'd4);
            if (k == 0) chk("loser_stall2", 32'(bus.stall2), 32'd1);
        end
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;

        txn(1'b0, 1'b1, 1'b0, 12'h123, '0, 32'hDEAD_BEEF, 4);
        txn(1'b1, 1'b0, 1'b1, 12'h8F0, 32'h0000_00A5, '0, 3);
        txn(1'b0, 1'b1, 1'b0, 12'h8F0, '0, 32'h0000_00A5, 4);
        txn(1'b0, 1'b1, 1'b1, 12'h0AB, 32'h0000_5A5A, '0, 3);
        txn(1'b1, 1'b1, 1'b0, 12'h0AB, '0, 32'h0000_5A5A, 4);

        // Request dropped during WAIT still completes exactly once
        push_exp(1'b0, 1'b0, 12'h0AB, 32'h0000_5A5A);
        drive(1'b0, 1'b1, 1'b0, 12'h0AB, '0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        drive(1'b0, 1'b0, 1'b0, 12'h0AB, '0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done1) cnt++;
        end
        chk("withdraw_done_count", 32'(cnt), 32'd1);
        chk("sb_leftover", 32'(sb.size()), 32'd0);

        // Latency-4 instance: one clean read, then a read aborted by reset
        @(posedge clk); #2;
        bus4.address1 = 12'h322;
        bus4.r_en1    = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus4.done1 && cyc < 40);
        chk("lat4_latency", 32'(cyc), 32'd7);
        chk("lat4_rdata",   bus4.rdata1, 32'h1234_5678);
        @(posedge clk); #2;
        bus4.r_en1 = 1'b0;
        @(posedge clk); #2;
        bus4.address1 = 12'h321;
        bus4.r_en1    = 1'b1;
        repeat (4) @(negedge clk);
        rst4 = 1'b0;
        #1;
        chk("abort_rdata1",   bus4.rdata1,        32'd0);
        chk("abort_done",     32'({bus4.done2, bus4.done1}), 32'd0);
        chk("abort_mem_en",   32'({bus4.mem_wren, bus4.mem_rden}), 32'd0);
        chk("abort_mem_addr", 32'(bus4.mem_addr), 32'd0);
        chk("abort_inv",      32'({bus4.inv2, bus4.inv1}),   32'd0);
        chk("abort_stall1",   32'(bus4.stall1),   32'd1);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus4.done1 | bus4.inv2) cnt++;
        end
        chk("abort_no_pulse", 32'(cnt), 32'd0);
        @(posedge clk); #2;
        rst4 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus4.done1 && cyc < 40);
        chk("reissue_latency", 32'(cyc), 32'd7);
        chk("reissue_rdata",   bus4.rdata1, 32'hCAFE_F00D);
        @(posedge clk); #2;
        bus4.r_en1 = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
